systolic_output_deskew: RTL

SYSTOLIC_OUTPUT_DESKEW -- requirements
Module: systolic_output_deskew

---
 rtl/systolic_output_deskew.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/systolic_output_deskew.sv
// Realigns the skewed per-column results of a systolic array into whole rows
// and buffers them in a small FIFO for a ready/valid consumer, one tile at a time.
module systolic_output_deskew #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned COLS       = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [COLS-1:0]                     in_valid,
    input  logic signed [ACC_WIDTH*COLS-1:0]    C_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [ACC_WIDTH*COLS-1:0]    C_out,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow,
    output logic                                misalign
);

    localparam int unsigned ROW_BITS = ACC_WIDTH * COLS;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RC_W     = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [ROW_BITS-1:0] tap_data;
    logic [COLS-1:0]     tap_vld;
    logic [ROW_BITS-1:0] al_data;
    logic [COLS-1:0]     al_vld;

    // Column j sits COLS-j registers deep so that all columns of a row meet at the taps
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int unsigned DEPTH = COLS - j;
        logic [ACC_WIDTH-1:0] dl_data [DEPTH];
        logic [DEPTH-1:0]     dl_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) dl_data[k] <= '0;
                dl_vld <= '0;
            end else begin
                dl_data[0] <= C_in[j*ACC_WIDTH +: ACC_WIDTH];
                dl_vld[0]  <= in_valid[j];
                for (int k = 1; k < DEPTH; k++) begin
                    dl_data[k] <= dl_data[k-1];
                    dl_vld[k]  <= dl_vld[k-1];
                end
            end
        end

        assign tap_data[j*ACC_WIDTH +: ACC_WIDTH] = dl_data[DEPTH-1];
        assign tap_vld[j]                         = dl_vld[DEPTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_data <= '0;
            al_vld  <= '0;
        end else begin
            al_data <= tap_data;
            al_vld  <= tap_vld;
        end
    end

    logic [ROW_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [RC_W-1:0]     wr_cnt, rd_cnt, rd_cnt_n;
    logic [ROW_BITS-1:0] head_n;
    logic                full, pop;
    logic                row_evt, wr_en, ovf_set, mis_set, clr, last_acc;

    assign full = (cnt == CNT_W'(FIFO_DEPTH));
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (clr) state_n = COLLECT;
            COLLECT: if (row_evt && wr_cnt == RC_W'(ROWS - 1)) state_n = DRAIN;
            DRAIN:   if (last_acc) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control strobes; a full row arriving with the FIFO full only lands if the head leaves the same cycle
    always_comb begin
        clr      = 1'b0;
        row_evt  = 1'b0;
        mis_set  = 1'b0;
        last_acc = 1'b0;
        case (state)
            IDLE:    clr = start;
            COLLECT: begin
                row_evt = &al_vld;
                mis_set = (|al_vld) && !(&al_vld);
            end
            DRAIN:   last_acc = pop && out_last;
            default: ;
        endcase
        wr_en   = row_evt && (!full || pop);
        ovf_set = row_evt && full && !pop;
    end

    always_comb begin
        rd_ptr_n = pop ? PTR_W'(rd_ptr + 1'b1) : rd_ptr;
        cnt_n    = CNT_W'(cnt + CNT_W'(wr_en) - CNT_W'(pop));
        rd_cnt_n = clr ? '0 : (pop ? RC_W'(rd_cnt + 1'b1) : rd_cnt);
        head_n   = mem[rd_ptr_n];
        if (wr_en && wr_ptr == rd_ptr_n) head_n = al_data;
        if (cnt_n == '0) head_n = '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= al_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            C_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            rd_ptr    <= rd_ptr_n;
            cnt       <= cnt_n;
            rd_cnt    <= rd_cnt_n;
            if (clr)          wr_cnt <= '0;
            else if (row_evt) wr_cnt <= RC_W'(wr_cnt + 1'b1);
            out_valid <= (cnt_n != '0);
            out_last  <= (cnt_n != '0) && (rd_cnt_n == RC_W'(ROWS - 1));
            C_out     <= head_n;
            busy      <= (state_n != IDLE);
            done      <= last_acc;
            overflow  <= clr ? 1'b0 : (overflow || ovf_set);
            misalign  <= clr ? 1'b0 : (misalign || mis_set);
        end
    end

endmodule
